// File: rtl/viterbi_pkg.sv
// Shared definitions for the 4-state, rate-1/2, K=3 hard-decision Viterbi decoder.
// Holds the state encodings, the ACS controller states and the trellis
// connection table (predecessors and branch-metric indices per next state).
// The traceback unit uses the same table.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int BM_W       = 2;
    localparam int NUM_BM     = 8;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } state_e;

    typedef enum logic {
        PMU_IDLE = 1'b0,
        PMU_RUN  = 1'b1
    } pmu_fsm_e;

    // Connection of one next state: candidate A is the predecessor with LSB 0,
    // candidate B the predecessor with LSB 1.
    typedef struct packed {
        logic [1:0] pred_a;
        logic [2:0] bm_a;
        logic [1:0] pred_b;
        logic [2:0] bm_b;
    } acs_conn_t;

    // Indexed by next state. The branch-metric index is 2*pred + u, where
    // u is the input bit and next state = {u, pred[1]}.
    localparam acs_conn_t ACS_TABLE [NUM_STATES] = '{
        '{pred_a: S00, bm_a: 3'd0, pred_b: S01, bm_b: 3'd2},  // S00
        '{pred_a: S10, bm_a: 3'd4, pred_b: S11, bm_b: 3'd6},  // S01
        '{pred_a: S00, bm_a: 3'd1, pred_b: S01, bm_b: 3'd3},  // S10
        '{pred_a: S10, bm_a: 3'd5, pred_b: S11, bm_b: 3'd7}   // S11
    };

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select cell for a single next state.
// Ports:
//   pm_a_i, bm_a_i   path metric / branch metric of candidate A (first predecessor)
//   pm_b_i, bm_b_i   path metric / branch metric of candidate B (second predecessor)
//   metric_o         selected (un-normalised) metric, one bit wider than a path metric
//   dec_o            1 only when B is strictly better than A
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int PM_W = 4
) (
    input  logic [PM_W-1:0] pm_a_i,
    input  logic [BM_W-1:0] bm_a_i,
    input  logic [PM_W-1:0] pm_b_i,
    input  logic [BM_W-1:0] bm_b_i,
    output logic [PM_W:0]   metric_o,
    output logic            dec_o
);

    logic [PM_W:0] cand_a;
    logic [PM_W:0] cand_b;

    // The extra bit keeps the sum exact before normalisation.
    assign cand_a = {1'b0, pm_a_i} + {{(PM_W + 1 - BM_W){1'b0}}, bm_a_i};
    assign cand_b = {1'b0, pm_b_i} + {{(PM_W + 1 - BM_W){1'b0}}, bm_b_i};

    // Ties favour candidate A, so the decision bit stays 0 on equality.
    assign dec_o    = (cand_b < cand_a);
    assign metric_o = dec_o ? cand_b : cand_a;

endmodule

// File: rtl/acs_pmu.sv
// Add-compare-select and path-metric unit for the 4-state Viterbi decoder.
// Takes the eight branch metrics of one received symbol, runs four ACS cells,
// normalises the new metrics so the smallest is 0 and registers them together
// with one survivor decision bit per state.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a new frame, re-initialise the metrics
//   in_valid          bm0..bm7 carry one symbol this cycle
//   bm0..bm7          branch metrics
//   pm0..pm3          registered path metrics of states 00, 01, 10, 11
//   dec               survivor decision bits, dec[i] for state i
//   out_valid         one-cycle pulse per accepted symbol
//   best_state        index of the smallest path metric (lowest index on ties)
//   frame_done        pulse together with out_valid of the last symbol of a frame
//   busy              a frame is in progress
module acs_pmu
    import viterbi_pkg::*;
#(
    parameter int PM_W      = 4,
    parameter int INIT_PM   = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    input  logic [BM_W-1:0] bm0,
    input  logic [BM_W-1:0] bm1,
    input  logic [BM_W-1:0] bm2,
    input  logic [BM_W-1:0] bm3,
    input  logic [BM_W-1:0] bm4,
    input  logic [BM_W-1:0] bm5,
    input  logic [BM_W-1:0] bm6,
    input  logic [BM_W-1:0] bm7,
    output logic [PM_W-1:0] pm0,
    output logic [PM_W-1:0] pm1,
    output logic [PM_W-1:0] pm2,
    output logic [PM_W-1:0] pm3,
    output logic [3:0]      dec,
    output logic            out_valid,
    output logic [1:0]      best_state,
    output logic            frame_done,
    output logic            busy
);

    pmu_fsm_e          state_q;
    logic [CNT_W-1:0]  count_q;
    logic [PM_W-1:0]   pm_q    [NUM_STATES];
    logic [3:0]        dec_q;
    logic              out_valid_q;
    logic              frame_done_q;

    logic [BM_W-1:0]   bm      [NUM_BM];
    logic [PM_W-1:0]   pm_init [NUM_STATES];
    logic [PM_W-1:0]   pm_src  [NUM_STATES];
    logic [PM_W:0]     raw     [NUM_STATES];
    logic [PM_W:0]     raw_min;
    logic [PM_W-1:0]   pm_d    [NUM_STATES];
    logic [3:0]        dec_d;
    logic [CNT_W-1:0]  count_d;
    logic              accept;

    assign bm      = '{bm0, bm1, bm2, bm3, bm4, bm5, bm6, bm7};
    assign pm_init = '{PM_W'(0), PM_W'(INIT_PM), PM_W'(INIT_PM), PM_W'(INIT_PM)};

    // A symbol arriving with start is the first of the new frame, so it
    // is compared against the initial metrics rather than the stored ones.
    assign pm_src  = start ? pm_init : pm_q;
    assign accept  = in_valid && (start || (state_q == PMU_RUN));
    assign count_d = (start ? '0 : count_q) + CNT_W'(1);

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        acs_cell #(.PM_W(PM_W)) u_acs_cell (
            .pm_a_i   (pm_src[ACS_TABLE[g].pred_a]),
            .bm_a_i   (bm[ACS_TABLE[g].bm_a]),
            .pm_b_i   (pm_src[ACS_TABLE[g].pred_b]),
            .bm_b_i   (bm[ACS_TABLE[g].bm_b]),
            .metric_o (raw[g]),
            .dec_o    (dec_d[g])
        );
    end

    // Normaliser: subtract the smallest new metric so the stored minimum is 0.
    // NOTE: every signal written in always_comb gets a value before any
    // conditional, otherwise synthesis infers a latch.
    always_comb begin
        raw_min = raw[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (raw[i] < raw_min) raw_min = raw[i];
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            pm_d[i] = PM_W'(raw[i] - raw_min);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PMU_IDLE;
            count_q      <= '0;
            pm_q         <= pm_init;
            dec_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (accept) begin
                pm_q        <= pm_d;
                dec_q       <= dec_d;
                count_q     <= count_d;
                out_valid_q <= 1'b1;
                if (count_d == CNT_W'(FRAME_LEN)) begin
                    frame_done_q <= 1'b1;
                    state_q      <= PMU_IDLE;
                end else begin
                    state_q      <= PMU_RUN;
                end
            end else if (start) begin
                pm_q    <= pm_init;
                count_q <= '0;
                state_q <= PMU_RUN;
            end
        end
    end

    always_comb begin
        logic [PM_W-1:0] min_v;
        min_v      = pm_q[0];
        best_state = 2'd0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_q[i] < min_v) begin
                min_v      = pm_q[i];
                best_state = 2'(i);
            end
        end
    end

    assign pm0        = pm_q[0];
    assign pm1        = pm_q[1];
    assign pm2        = pm_q[2];
    assign pm3        = pm_q[3];
    assign dec        = dec_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == PMU_RUN);

endmodule

// File: tb/tb_acs_pmu.sv
// Self-checking bench for acs_pmu: directed trellis cases plus randomized
// traffic, compared against a behavioural Viterbi path-metric model.
module tb_acs_pmu;

    localparam int PM_W      = 4;
    localparam int INIT_PM   = 4;
    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic [1:0]      bm0 = '0, bm1 = '0, bm2 = '0, bm3 = '0;
    logic [1:0]      bm4 = '0, bm5 = '0, bm6 = '0, bm7 = '0;
    logic [PM_W-1:0] pm0, pm1, pm2, pm3;
    logic [3:0]      dec;
    logic            out_valid;
    logic [1:0]      best_state;
    logic            frame_done;
    logic            busy;

    acs_pmu #(
        .PM_W(PM_W), .INIT_PM(INIT_PM), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .bm0(bm0), .bm1(bm1), .bm2(bm2), .bm3(bm3),
        .bm4(bm4), .bm5(bm5), .bm6(bm6), .bm7(bm7),
        .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3),
        .dec(dec), .out_valid(out_valid), .best_state(best_state),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int      m [4];
    bit      m_busy;
    int      m_cnt;
    bit [3:0] m_dec;
    bit      m_ov;
    bit      m_fd;
    int      bmv [8];

    int ov_seen;
    int fd_seen;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m      = '{0, INIT_PM, INIT_PM, INIT_PM};
        m_busy = 1'b0;
        m_cnt  = 0;
        m_dec  = '0;
        m_ov   = 1'b0;
        m_fd   = 1'b0;
    endtask

    // Viterbi step from the trellis rule next = {u, s[1]}: the two
    // predecessors of ns are {ns[0],0} and {ns[0],1}; the branch from s
    // with input u uses bm[2*s+u].
    task automatic model_step(input bit st, input bit iv);
        int nm [4];
        int mn;
        bit [3:0] nd;
        if (st) begin
            m      = '{0, INIT_PM, INIT_PM, INIT_PM};
            m_cnt  = 0;
            m_busy = 1'b1;
        end
        m_ov = 1'b0;
        m_fd = 1'b0;
        if (iv && m_busy) begin
            for (int ns = 0; ns < 4; ns++) begin
                int u, pa, pb, ca, cb;
                u  = ns / 2;
                pa = 2 * (ns % 2);
                pb = pa + 1;
                ca = m[pa] + bmv[2 * pa + u];
                cb = m[pb] + bmv[2 * pb + u];
                nm[ns] = (cb < ca) ? cb : ca;
                nd[ns] = (cb < ca);
            end
            mn = nm[0];
            for (int i = 1; i < 4; i++) if (nm[i] < mn) mn = nm[i];
            for (int i = 0; i < 4; i++) m[i] = nm[i] - mn;
            m_dec = nd;
            m_cnt++;
            m_ov = 1'b1;
            if (m_cnt == FRAME_LEN) begin
                m_fd   = 1'b1;
                m_busy = 1'b0;
            end
        end
    endtask

    function automatic int model_best();
        int b = 0;
        for (int i = 1; i < 4; i++) if (m[i] < m[b]) b = i;
        return b;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".pm0"}, int'(pm0), m[0]);
        check({tag, ".pm1"}, int'(pm1), m[1]);
        check({tag, ".pm2"}, int'(pm2), m[2]);
        check({tag, ".pm3"}, int'(pm3), m[3]);
        check({tag, ".dec"}, int'(dec), int'(m_dec));
        check({tag, ".out_valid"}, int'(out_valid), int'(m_ov));
        check({tag, ".frame_done"}, int'(frame_done), int'(m_fd));
        check({tag, ".busy"}, int'(busy), int'(m_busy));
        check({tag, ".best_state"}, int'(best_state), model_best());
    endtask

    task automatic set_bm(input int b0, b1, b2, b3, b4, b5, b6, b7);
        bmv = '{b0, b1, b2, b3, b4, b5, b6, b7};
    endtask

    task automatic rand_bm();
        for (int i = 0; i < 8; i++) bmv[i] = int'($urandom_range(0, 2));
    endtask

    // Called one time unit after a rising edge: drive, clock once, compare.
    task automatic step(input string tag, input bit st, input bit iv);
        start    = st;
        in_valid = iv;
        bm0 = 2'(bmv[0]); bm1 = 2'(bmv[1]); bm2 = 2'(bmv[2]); bm3 = 2'(bmv[3]);
        bm4 = 2'(bmv[4]); bm5 = 2'(bmv[5]); bm6 = 2'(bmv[6]); bm7 = 2'(bmv[7]);
        @(posedge clk);
        #1;
        model_step(st, iv);
        if (out_valid) ov_seen++;
        if (frame_done) fd_seen++;
        check_all(tag);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        set_bm(0, 0, 0, 0, 0, 0, 0, 0);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset");

        // Received symbol 00, three times.
        step("start00", 1'b1, 1'b0);
        set_bm(0, 2, 2, 0, 1, 1, 1, 1);
        step("sym00_1", 1'b0, 1'b1);
        check("tp_s1_pm", {28'd0, pm0, pm1, pm2, pm3}, 'h0525);
        check("tp_s1_best", int'(best_state), 0);
        step("sym00_2", 1'b0, 1'b1);
        check("tp_s2_pm", {28'd0, pm0, pm1, pm2, pm3}, 'h0323);
        step("sym00_3", 1'b0, 1'b1);
        check("tp_s3_pm", {28'd0, pm0, pm1, pm2, pm3}, 'h0323);
        check("tp_s3_dec", int'(dec), 0);

        // Start then a single symbol 11.
        step("start11", 1'b1, 1'b0);
        set_bm(2, 0, 0, 2, 1, 1, 1, 1);
        step("sym11", 1'b0, 1'b1);
        check("tp_11_pm", {28'd0, pm0, pm1, pm2, pm3}, 'h2505);
        check("tp_11_best", int'(best_state), 2);

        // Every state ties against the initial metrics.
        set_bm(1, 1, 1, 1, 1, 1, 1, 1);
        step("tie", 1'b1, 1'b1);
        check("tp_tie_pm", {28'd0, pm0, pm1, pm2, pm3}, 'h0404);
        check("tp_tie_dec", int'(dec), 0);

        // Full frame with one-cycle gaps, then a ninth symbol that is ignored.
        step("frame_start", 1'b1, 1'b0);
        ov_seen = 0;
        fd_seen = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            rand_bm();
            step("frame_sym", 1'b0, 1'b1);
            step("frame_gap", 1'b0, 1'b0);
        end
        check("frame_ov_count", ov_seen, FRAME_LEN);
        check("frame_fd_count", fd_seen, 1);
        rand_bm();
        step("ninth_sym", 1'b0, 1'b1);

        // Restart with a symbol mid-frame at count 5.
        step("mid_start", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            rand_bm();
            step("mid_sym", 1'b0, 1'b1);
        end
        fd_seen = 0;
        rand_bm();
        step("mid_restart", 1'b1, 1'b1);
        for (int i = 0; i < FRAME_LEN - 2; i++) begin
            rand_bm();
            step("mid_tail", 1'b0, 1'b1);
        end
        check("mid_no_early_fd", fd_seen, 0);
        rand_bm();
        step("mid_last", 1'b0, 1'b1);
        check("mid_fd_count", fd_seen, 1);

        // Randomized traffic: occasional start, random gaps.
        for (int i = 0; i < 400; i++) begin
            rand_bm();
            step("rand", ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset between edges in the middle of a frame.
        step("ar_start", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rand_bm();
            step("ar_sym", 1'b0, 1'b1);
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #2 rst_n = 1'b1;
        rand_bm();
        step("post_reset_ignored", 1'b0, 1'b1);
        rand_bm();
        step("post_reset_start", 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
